// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the round-robin FIFO write-port arbiter.
// master: the arbiter's view; slave: the requesters/FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_WIDTH     = 2,
  parameter int unsigned MEMORY_WIDTH = 8
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_last;
  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            w_full;
  logic                            w_en;
  logic [MEMORY_WIDTH-1:0]         wdata;
  logic [ID_WIDTH-1:0]             owner_id;
  logic                            busy;

  modport master (
    input  req_valid, req_last, req_data, w_full,
    output req_ready, w_en, wdata, owner_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, w_full,
    input  req_ready, w_en, wdata, owner_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, one grant per burst.
// Optional macro FIFO_ARB_BEAT_CNT_EN adds a saturating 16-bit beat_total write counter.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_WIDTH     = 2,
  parameter int unsigned MEMORY_WIDTH = 8,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
`ifdef FIFO_ARB_BEAT_CNT_EN
  ,
  output logic [15:0]       beat_total
`endif
);

  localparam int unsigned SUM_WIDTH = ID_WIDTH + 1;
  localparam logic [7:0]          BURST_LEN = 8'(MAX_BURST);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [SUM_WIDTH-1:0] NUM_REQ_S = SUM_WIDTH'(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     owner_id;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [7:0]              beat_cnt;

  logic                    own_valid;
  logic                    own_last;
  logic [MEMORY_WIDTH-1:0] own_data;
  logic                    xfer;
  logic [2*NUM_REQ-1:0]    rot_valid;
  logic [ID_WIDTH-1:0]     offset;
  logic [SUM_WIDTH-1:0]    pick_sum;
  logic [ID_WIDTH-1:0]     pick;
  logic [ID_WIDTH-1:0]     rr_next;

  // Owner slice selection
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_id == ID_WIDTH'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*MEMORY_WIDTH +: MEMORY_WIDTH];
      end
    end
  end

  assign xfer = (state == BURST) && own_valid && !bus.w_full;

  // Round-robin pick: first valid at or after rr_ptr, via a rotated copy of req_valid
  always_comb begin
    rot_valid = {bus.req_valid, bus.req_valid} >> rr_ptr;
    offset    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) offset = ID_WIDTH'(i);
    end
    pick_sum = SUM_WIDTH'(rr_ptr) + SUM_WIDTH'(offset);
    pick     = (pick_sum >= NUM_REQ_S) ? ID_WIDTH'(pick_sum - NUM_REQ_S) : ID_WIDTH'(pick_sum);
  end

  assign rr_next = (owner_id == LAST_ID) ? '0 : owner_id + ID_WIDTH'(1);

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = xfer && (owner_id == ID_WIDTH'(i));
    end
  end

  assign bus.w_en     = xfer;
  assign bus.wdata    = own_data;
  assign bus.owner_id = owner_id;
  assign bus.busy     = (state == BURST);

  // Grant FSM; a full stall simply produces no xfer and holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            owner_id <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
            if ((beat_cnt + 8'd1 == BURST_LEN) || own_last) begin
              state  <= IDLE;
              rr_ptr <= rr_next;
            end
          end else if (!own_valid) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_BEAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_total <= '0;
    end else if (xfer && (beat_total != 16'hFFFF)) begin
      beat_total <= beat_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios push cycle-exact expected writes,
// a negedge monitor pops and compares every w_en beat.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int MW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .MEMORY_WIDTH(MW)) bus ();
`ifdef FIFO_ARB_BEAT_CNT_EN
  logic [15:0] beat_total;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IW), .MEMORY_WIDTH(MW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_ARB_BEAT_CNT_EN
    ,
    .beat_total (beat_total)
`endif
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    int         at;
  } beat_t;

  beat_t       expq[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          seq[NR];
  int          exp_n[NR];
  int          last_at[NR];
  logic [NR-1:0] acc = '0;
  int          t0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: protocol properties every cycle, scoreboard pop on each write
  always @(negedge clk) begin
    beat_t e;
    acc = bus.req_valid & bus.req_ready;
    chk("ready_matches_wen", 32'(bus.req_ready),
        bus.w_en ? 32'(4'b0001 << bus.owner_id) : 32'd0);
    if (bus.w_full) chk("no_write_when_full", 32'(bus.w_en), 32'd0);
    if (bus.w_en === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got owner %0d data %0h, expected no write (cycle %0d)",
                 bus.owner_id, bus.wdata, cyc);
      end else begin
        e = expq.pop_front();
        chk("write_owner", 32'(bus.owner_id), 32'(e.id));
        chk("write_data", 32'(bus.wdata), 32'(e.data));
        chk("write_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic drive_src();
    for (int i = 0; i < NR; i++) begin
      bus.req_data[i*MW +: MW] = {4'(i), 4'(seq[i])};
      bus.req_last[i]          = (seq[i] == last_at[i]);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) seq[i]++;
      drive_src();
    end
  endtask

  task automatic expect_beat(int id, int at);
    beat_t e;
    e.id   = id;
    e.data = {4'(id), 4'(exp_n[id])};
    e.at   = at;
    expq.push_back(e);
    exp_n[id]++;
  endtask

  task automatic drain(string name);
    chk(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.w_full    = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.w_full    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      seq[i]     = 0;
      exp_n[i]   = 0;
      last_at[i] = -1;
    end
    drive_src();

    // Idle after reset
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_wen", 32'(bus.w_en), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_ready", 32'(bus.req_ready), 32'd0);
      chk("idle_owner", 32'(bus.owner_id), 32'd0);
    end

    // Single requester 2: two back-to-back grants, second ends with last on its max beat
    t0 = cyc;
    bus.req_valid = 4'b0100;
    last_at[2]    = seq[2] + 7;
    drive_src();
    for (int b = 0; b < MB; b++) expect_beat(2, t0 + 1 + b);
    for (int b = 0; b < MB; b++) expect_beat(2, t0 + 6 + b);
    chk("arb_latency_busy", 32'(bus.busy), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) chk("single_owner", 32'(bus.owner_id), 32'd2);
      if (c == 5) chk("gap_busy", 32'(bus.busy), 32'd0);
      if (c == 6) chk("regrant_busy", 32'(bus.busy), 32'd1);
    end
    bus.req_valid = '0;
    last_at[2]    = -1;
    drive_src();
    step(2);
    drain("single_drain");

    // All requesters continuously valid: rotation 0,1,2,3,0
    do_reset();
    t0 = cyc;
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < MB; b++) expect_beat(g % NR, t0 + 1 + 5*g + b);
    step(25);
    bus.req_valid = '0;
    step(2);
    drain("rotate_drain");

    // Full stall in the middle of requester 1's burst
    do_reset();
    t0 = cyc;
    bus.req_valid = 4'b0010;
    expect_beat(1, t0 + 1);
    expect_beat(1, t0 + 2);
    expect_beat(1, t0 + 8);
    expect_beat(1, t0 + 9);
    step(3);
    bus.w_full = 1'b1;
    step(1);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    chk("stall_owner", 32'(bus.owner_id), 32'd1);
    step(4);
    bus.w_full = 1'b0;
    step(2);
    bus.req_valid = '0;
    step(2);
    drain("stall_drain");

    // Requester 3 ends early with last; requester 0 waits without preempting
    do_reset();
    t0 = cyc;
    bus.req_valid = 4'b1000;
    last_at[3]    = seq[3] + 1;
    drive_src();
    expect_beat(3, t0 + 1);
    expect_beat(3, t0 + 2);
    for (int b = 0; b < MB; b++) expect_beat(0, t0 + 4 + b);
    step(1);
    bus.req_valid = 4'b1001;
    step(3);
    chk("after_last_owner", 32'(bus.owner_id), 32'd0);
    step(4);
    bus.req_valid = '0;
    last_at[3]    = -1;
    drive_src();
    step(2);
    drain("last_drain");

    // Owner valid drop ends a burst, both while writing and while full
    do_reset();
    t0 = cyc;
    bus.req_valid = 4'b0110;
    expect_beat(1, t0 + 1);
    expect_beat(2, t0 + 4);
    step(2);
    bus.req_valid = 4'b0100;
    step(3);
    bus.w_full = 1'b1;
    step(1);
    bus.req_valid = '0;
    step(1);
    bus.w_full = 1'b0;
    chk("drop_full_exit_busy", 32'(bus.busy), 32'd0);
    step(2);
    drain("drop_drain");

`ifdef FIFO_ARB_BEAT_CNT_EN
    // Beat counter: 10 bursts of 4, then reset in the middle of a burst
    do_reset();
    t0 = cyc;
    bus.req_valid = 4'b0001;
    for (int g = 0; g < 10; g++)
      for (int b = 0; b < MB; b++) expect_beat(0, t0 + 1 + 5*g + b);
    step(50);
    bus.req_valid = '0;
    step(1);
    chk("beat_total_40", 32'(beat_total), 32'd40);
    t0 = cyc;
    bus.req_valid = 4'b0001;
    expect_beat(0, t0 + 1);
    expect_beat(0, t0 + 2);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.req_valid = '0;
    chk("beat_total_rst", 32'(beat_total), 32'd0);
    chk("rst_mid_burst_busy", 32'(bus.busy), 32'd0);
    step(2);
    drain("cnt_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
